// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcode/funct constants, FSM and ALU enums shared by the multi-cycle core
package multicycle_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    // Loads, stores and branches all use the adder; sub exists only on OP.
    function automatic alu_op_t alu_sel(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic sub);
        if (opcode != OPC_OP && opcode != OPC_OPIMM) return ALU_ADD;
        case (f3)
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return (opcode == OPC_OP && sub) ? ALU_SUB : ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// mc_reg_file: 2R/1W register file, x0 hardwired to zero, async active-low clear
module mc_reg_file
    import multicycle_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: RV32I-subset core, 3-5 states per instruction over one req/ack memory port
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic            retire_q, retire_d, halted_q, halted_d;

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [11:0]     imm12;
    logic [XLEN-1:0] imm, op_b, alu_res, rf_rdata1, rf_rdata2;
    logic            is_op, is_opimm, is_load, is_store, is_branch;
    logic            legal, wide, taken, misaligned, rf_we;
    alu_op_t         alu_op;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    assign is_op     = opcode == OPC_OP;
    assign is_opimm  = opcode == OPC_OPIMM;
    assign is_load   = opcode == OPC_LOAD;
    assign is_store  = opcode == OPC_STORE;
    assign is_branch = opcode == OPC_BRANCH;

    // Branch immediate is kept in halfword units; EXEC shifts it back to bytes.
    assign imm12 = is_store  ? {ir_q[31:25], ir_q[11:7]} :
                   is_branch ? {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]} : ir_q[31:20];
    assign imm   = {{(XLEN-12){imm12[11]}}, imm12};

    assign wide  = ((rs1 >> AW) != 5'd0) ||
                   ((is_op || is_store || is_branch) && (rs2 >> AW) != 5'd0) ||
                   ((is_op || is_opimm || is_load) && (rd >> AW) != 5'd0);
    assign legal = !wide && (
                   (is_op && f3 != 3'b011 && (f7 == F7_BASE || (f7 == F7_SUB && f3 == F3_ADD))) ||
                   (is_opimm && f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND}) ||
                   ((is_load || is_store) && f3 == F3_LW) ||
                   (is_branch && f3 inside {F3_BEQ, F3_BNE}));

    assign alu_op = alu_sel(opcode, f3, f7 == F7_SUB);
    assign op_b   = is_op ? b_q : imm;

    always_comb begin
        alu_res = a_q + op_b;
        case (alu_op)
            ALU_SUB: alu_res = a_q - op_b;
            ALU_AND: alu_res = a_q & op_b;
            ALU_OR:  alu_res = a_q | op_b;
            ALU_XOR: alu_res = a_q ^ op_b;
            ALU_SLT: alu_res = XLEN'($signed(a_q) < $signed(op_b));
            ALU_SLL: alu_res = a_q << op_b[SW-1:0];
            ALU_SRL: alu_res = a_q >> op_b[SW-1:0];
            default: alu_res = a_q + op_b;
        endcase
    end

    assign taken      = (a_q == b_q) != (f3 == F3_BNE);
    assign misaligned = |(alu_res & XLEN'(XLEN/8 - 1));
    assign rf_we      = state_q == WB;

    mc_reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs1[AW-1:0]),
        .raddr2 (rs2[AW-1:0]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rd[AW-1:0]),
        .wdata  (is_load ? mdr_q : alu_out_q)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        retire_d  = 1'b0;
        case (state_q)
            FETCH: if (mem_req_q && mem_ack) begin
                ir_d    = mem_rdata[31:0];
                state_d = DECODE;
            end
            DECODE: begin
                a_d     = rf_rdata1;
                b_d     = rf_rdata2;
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                alu_out_d = alu_res;
                if (is_branch) begin
                    pc_d     = taken ? pc_q + (imm << 1) : pc_q + XLEN'(4);
                    retire_d = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = (is_load || is_store) ? (misaligned ? HALT : MEM) : WB;
                end
            end
            MEM: if (mem_req_q && mem_ack) begin
                mdr_d    = mem_rdata;
                pc_d     = is_store ? pc_q + XLEN'(4) : pc_q;
                retire_d = is_store;
                state_d  = is_store ? FETCH : WB;
            end
            WB: begin
                pc_d     = pc_q + XLEN'(4);
                retire_d = 1'b1;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Port outputs are registered from the next state so they hold through any ack wait.
    assign mem_req_d   = state_d == FETCH || state_d == MEM;
    assign mem_we_d    = state_d == MEM && is_store;
    assign mem_addr_d  = (state_d == MEM) ? alu_out_d : pc_d;
    assign mem_wdata_d = (state_d == MEM) ? b_q : '0;
    assign halted_d    = state_d == HALT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs against a variable-latency memory model
module tb_multicycle_core;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;
    localparam logic [31:0] HALT_I = 32'h0000_0073;
    localparam int D = 256;

    logic        clock, reset, mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    multicycle_core dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .retire(retire), .halted(halted)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    logic [31:0] mem [128];
    logic [31:0] acc_addr [64];
    logic        acc_we [64];
    int nvec = 0, nfail = 0, pidx = 0, delay = 0, wcnt = 0, nacc = 0, unstable = 0, rcnt = 0, cyc = 0;
    logic        pend = 0, p_we = 0, h_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0, h_addr = 0, h_wdata = 0;

    // Memory model: ack after `delay` withheld cycles; stores land after the completing edge.
    initial begin
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clock);
            if (pend && p_we) mem[p_addr[8:2]] = p_wdata;
            pend = 0;
            if (!reset || !mem_req) begin
                mem_ack = 0;
                wcnt = 0;
            end else begin
                if (wcnt == 0) begin
                    h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
                    unstable++;
                end
                if (wcnt >= delay) begin
                    mem_ack = 1;
                    mem_rdata = mem[mem_addr[8:2]];
                    pend = 1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
                    if (nacc < 64) begin
                        acc_addr[nacc] = mem_addr;
                        acc_we[nacc] = mem_we;
                    end
                    nacc++;
                    wcnt = 0;
                end else begin
                    mem_ack = 0;
                    wcnt++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (reset && retire === 1'b1) rcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, rs1, f3, rd);
        return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd, input logic [6:0] opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, rs2, rs1);
        logic [11:0] i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int off, rs2, rs1, f3);
        logic [12:0] o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'b1100011};
    endfunction

    task automatic put(input logic [31:0] w);
        mem[pidx] = w;
        pidx++;
    endtask

    task automatic hold_reset();
        reset = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_BEEF;
        pidx = 0; nacc = 0; rcnt = 0; unstable = 0;
    endtask

    task automatic run(input int bound);
        reset = 1;
        cyc = 0;
        while (halted !== 1'b1 && cyc < bound) begin
            @(posedge clock);
            #1 cyc++;
        end
    endtask

    task automatic load_sum();
        put(enc_i(5, 0, 0, 1, OPI));
        put(enc_i(7, 0, 0, 2, OPI));
        put(enc_r(7'h00, 2, 1, 0, 3));
        put(enc_s(16, 3, 0));
        put(HALT_I);
    endtask

    logic [31:0] exp_alu [18] = '{32'h8, 32'hFFFF_FFFD, 32'hFFFF_FFF5, 32'h1, 32'h0,
                                  32'hFFFF_0000, 32'h0007_FFFF, 32'h1A, 32'hF0, 32'hFFFF_FFFD,
                                  32'h8, 32'h1, 32'h0, 32'h3F8, 32'h15, 32'hFFFF_FFFF,
                                  32'h0, 32'h1};

    initial begin
        reset = 0;
        hold_reset();
        load_sum();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pc", pc, 0);
        chk("rst_retire", {31'd0, retire}, 0);
        chk("rst_halted", {31'd0, halted}, 0);

        // Zero-wait sum program; its store overwrites the halt word, which then decodes illegal.
        run(200);
        chk("sum_cycles", cyc, 19);
        chk("sum_mem16", mem[4], 12);
        chk("sum_retires", rcnt, 4);
        chk("sum_naccess", nacc, 6);
        chk("sum_st_addr", acc_addr[4], 16);
        chk("sum_st_we", {31'd0, acc_we[4]}, 1);
        repeat (5) @(negedge clock);
        chk("halt_sticky", {31'd0, halted}, 1);
        chk("halt_pc", pc, 16);
        chk("halt_no_req", {31'd0, mem_req}, 0);
        chk("halt_no_retire", rcnt, 4);

        hold_reset();
        load_sum();
        delay = 2;
        run(300);
        chk("slow_cycles", cyc, 31);
        chk("slow_mem16", mem[4], 12);
        chk("slow_retires", rcnt, 4);
        chk("slow_naccess", nacc, 6);
        chk("slow_stable", unstable, 0);

        hold_reset();
        delay = 0;
        put(enc_i(3, 0, 0, 1, OPI));
        put(enc_i(3, 0, 0, 2, OPI));
        put(enc_b(8, 2, 1, 0));
        put(enc_s(100, 1, 0));
        put(enc_b(8, 2, 1, 1));
        put(HALT_I);
        put(HALT_I);
        run(200);
        chk("br_cycles", cyc, 17);
        chk("beq_target", acc_addr[3], 16);
        chk("bne_fallthru", acc_addr[4], 20);
        chk("br_retires", rcnt, 4);
        chk("br_pc", pc, 20);

        hold_reset();
        put(enc_i(6, 0, 3'b010, 6, 7'b0000011));
        put(HALT_I);
        run(200);
        chk("mis_cycles", cyc, 4);
        chk("mis_halted", {31'd0, halted}, 1);
        chk("mis_naccess", nacc, 1);
        chk("mis_retires", rcnt, 0);
        chk("mis_pc", pc, 0);

        hold_reset();
        delay = 1;
        put(enc_i(-8, 0, 0, 1, OPI));
        put(enc_i(13, 0, 0, 2, OPI));
        put(enc_i(33, 0, 0, 9, OPI));
        put(enc_i(1, 0, 0, 5, OPI));
        put(enc_r(7'h00, 2, 1, 7, 3));  put(enc_s(D + 0, 3, 0));
        put(enc_r(7'h00, 2, 1, 6, 3));  put(enc_s(D + 4, 3, 0));
        put(enc_r(7'h00, 2, 1, 4, 3));  put(enc_s(D + 8, 3, 0));
        put(enc_r(7'h00, 2, 1, 2, 3));  put(enc_s(D + 12, 3, 0));
        put(enc_r(7'h00, 1, 2, 2, 3));  put(enc_s(D + 16, 3, 0));
        put(enc_r(7'h00, 2, 1, 1, 3));  put(enc_s(D + 20, 3, 0));
        put(enc_r(7'h00, 2, 1, 5, 3));  put(enc_s(D + 24, 3, 0));
        put(enc_r(7'h00, 9, 2, 1, 3));  put(enc_s(D + 28, 3, 0));
        put(enc_i(240, 1, 7, 3, OPI));  put(enc_s(D + 32, 3, 0));
        put(enc_i(-16, 2, 6, 3, OPI));  put(enc_s(D + 36, 3, 0));
        put(enc_i(5, 2, 4, 3, OPI));    put(enc_s(D + 40, 3, 0));
        put(enc_i(-7, 1, 2, 3, OPI));   put(enc_s(D + 44, 3, 0));
        put(enc_i(13, 2, 2, 3, OPI));   put(enc_s(D + 48, 3, 0));
        put(enc_i(1024, 1, 0, 3, OPI)); put(enc_s(D + 52, 3, 0));
        put(enc_r(7'h20, 1, 2, 0, 3));  put(enc_s(D + 56, 3, 0));
        put(enc_r(7'h20, 5, 0, 0, 3));  put(enc_s(D + 60, 3, 0));
        put(enc_i(9, 0, 0, 0, OPI));
        put(enc_r(7'h00, 0, 0, 0, 4));  put(enc_s(D + 64, 4, 0));
        put(enc_i(D + 60, 0, 2, 7, 7'b0000011));
        put(enc_i(2, 7, 0, 8, OPI));    put(enc_s(D + 68, 8, 0));
        put(HALT_I);
        run(2000);
        chk("alu_halted", {31'd0, halted}, 1);
        chk("alu_retires", rcnt, 42);
        chk("alu_stable", unstable, 0);
        for (int k = 0; k < 18; k++) chk($sformatf("alu_res%0d", k), mem[D/4 + k], exp_alu[k]);

        // Reset in the middle of a withheld fetch, then restart from RESET_PC.
        hold_reset();
        delay = 0;
        load_sum();
        reset = 1;
        repeat (12) @(negedge clock);
        #2 delay = 20;
        for (int i = 0; i < 40 && !(mem_req === 1'b1 && mem_ack === 1'b0 && pc != 0); i++)
            @(negedge clock);
        chk("pend_req", {31'd0, mem_req}, 1);
        chk("pend_ack", {31'd0, mem_ack}, 0);
        #2 reset = 0;
        #1;
        chk("async_req_drop", {31'd0, mem_req}, 0);
        chk("async_pc", pc, 0);
        chk("async_addr", mem_addr, 0);
        delay = 0;
        repeat (2) @(negedge clock);
        nacc = 0;
        reset = 1;
        repeat (4) @(negedge clock);
        chk("restart_naccess", {31'd0, nacc > 0}, 1);
        chk("restart_addr", acc_addr[0], 0);
        chk("restart_we", {31'd0, acc_we[0]}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
